// File: rtl/udp_frame_gen.sv
// udp_frame_gen: emits one Ethernet II / IPv4 / UDP frame per start pulse as a byte
// stream (preamble, headers, 4-byte tag, video RAM payload, FCS, inter-frame gap).
// Handshake: start_sending is a single-cycle request honoured only while busy=0;
// tx_en qualifies tx_data and there is no backpressure, so every state runs to completion.
module udp_frame_gen #(
    parameter int          PAYLOAD_LEN = 1024,
    parameter int          ADDR_W      = 20,
    parameter logic [47:0] SRC_MAC     = 48'h000A35_000001,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFF_FFFFFF,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0101,
    parameter logic [15:0] UDP_PORT    = 16'd4660
) (
    input  logic              clk125MHz,
    input  logic              RST_N,
    input  logic              start_sending,
    input  logic [15:0]       segment_num,
    input  logic [7:0]        txid,
    input  logic [7:0]        aux,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_FCS      = 3'd4,
        S_IFG      = 3'd5
    } state_t;

    // Last byte-counter value of each state
    localparam logic [15:0] PRE_LAST  = 16'd7;
    localparam logic [15:0] HDR_LAST  = 16'd41;
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_LEN + 3);
    localparam logic [15:0] FCS_LAST  = 16'd3;
    localparam logic [15:0] IFG_LAST  = 16'd11;
    // RAM address advances while the next data byte still needs fetching
    localparam logic [15:0] ADDR_STOP = 16'(PAYLOAD_LEN + 2);

    localparam logic [ADDR_W-1:0] PL_A     = ADDR_W'(PAYLOAD_LEN);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    localparam logic [15:0] L_IP  = 16'(32 + PAYLOAD_LEN);
    localparam logic [15:0] L_UDP = 16'(12 + PAYLOAD_LEN);

    // IPv4 header checksum is fixed by the parameters, so it is folded at elaboration
    localparam logic [31:0] CS_SUM = 32'h4500 + {16'h0, L_IP} + 32'h4000 + 32'h4011
                                   + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
                                   + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
    localparam logic [31:0] CS_F1   = {16'h0, CS_SUM[15:0]} + {16'h0, CS_SUM[31:16]};
    localparam logic [31:0] CS_F2   = {16'h0, CS_F1[15:0]} + {16'h0, CS_F1[31:16]};
    localparam logic [15:0] IP_CSUM = ~CS_F2[15:0];

    // All 42 header bytes, first transmitted byte in the MSBs
    localparam int HDR_BITS = 336;
    localparam logic [HDR_BITS-1:0] HDR = {
        DST_MAC, SRC_MAC, 16'h0800,
        16'h4500, L_IP, 16'h0000, 16'h4000, 8'h40, 8'h11, IP_CSUM, SRC_IP, DST_IP,
        UDP_PORT, UDP_PORT, L_UDP, 16'h0000
    };

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         cnt;
    logic [15:0]         seg_q;
    logic [7:0]          txid_q;
    logic [7:0]          aux_q;
    logic [31:0]         crc;
    logic [31:0]         fcs;
    logic [7:0]          cur_byte;
    logic                cur_en;
    logic                crc_upd;
    logic [HDR_BITS-1:0] hdr_shift;

    // Reflected CRC-32 (poly 0xEDB88320), one byte LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state: each state ends after a fixed byte count
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start_sending)     state_nxt = S_PREAMBLE;
            S_PREAMBLE: if (cnt == PRE_LAST)   state_nxt = S_HEADER;
            S_HEADER:   if (cnt == HDR_LAST)   state_nxt = S_PAYLOAD;
            S_PAYLOAD:  if (cnt == PAY_LAST)   state_nxt = S_FCS;
            S_FCS:      if (cnt == FCS_LAST)   state_nxt = S_IFG;
            S_IFG:      if (cnt == IFG_LAST)   state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // State register and per-state byte counter (cleared on every state change)
    always_ff @(posedge clk125MHz) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == S_IDLE)
                cnt <= 16'd0;
            else
                cnt <= cnt + 16'd1;
        end
    end

    // Output byte mux: selects the byte for the current state/counter position
    always_comb begin
        cur_byte  = 8'h00;
        cur_en    = 1'b0;
        crc_upd   = 1'b0;
        fcs       = ~crc;
        hdr_shift = HDR << {cnt[5:0], 3'b000};
        case (state)
            S_PREAMBLE: begin
                cur_en   = 1'b1;
                cur_byte = (cnt == PRE_LAST) ? 8'hD5 : 8'h55;
            end
            S_HEADER: begin
                cur_en   = 1'b1;
                crc_upd  = 1'b1;
                cur_byte = hdr_shift[HDR_BITS-1 -: 8];
            end
            S_PAYLOAD: begin
                cur_en  = 1'b1;
                crc_upd = 1'b1;
                case (cnt)
                    16'd0:   cur_byte = txid_q;
                    16'd1:   cur_byte = aux_q;
                    16'd2:   cur_byte = seg_q[15:8];
                    16'd3:   cur_byte = seg_q[7:0];
                    default: cur_byte = ram_data;
                endcase
            end
            S_FCS: begin
                cur_en = 1'b1;
                case (cnt[1:0])
                    2'd0:    cur_byte = fcs[7:0];
                    2'd1:    cur_byte = fcs[15:8];
                    2'd2:    cur_byte = fcs[23:16];
                    default: cur_byte = fcs[31:24];
                endcase
            end
            default: begin
                cur_byte = 8'h00;
                cur_en   = 1'b0;
            end
        endcase
    end

    assign tx_data   = cur_byte;
    assign tx_en     = cur_en;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Request fields are captured once at frame start and held for the whole frame
    always_ff @(posedge clk125MHz) begin
        if (!RST_N) begin
            seg_q  <= 16'd0;
            txid_q <= 8'd0;
            aux_q  <= 8'd0;
        end else if (state == S_IDLE && start_sending) begin
            seg_q  <= segment_num;
            txid_q <= txid;
            aux_q  <= aux;
        end
    end

    // Running CRC over header and payload bytes; reinitialised whenever idle
    always_ff @(posedge clk125MHz) begin
        if (!RST_N)
            crc <= 32'hFFFFFFFF;
        else if (state == S_IDLE)
            crc <= 32'hFFFFFFFF;
        else if (crc_upd)
            crc <= crc32_byte(crc, cur_byte);
    end

    // RAM address: segment base loaded at start, stepped one cycle ahead of each data byte
    always_ff @(posedge clk125MHz) begin
        if (!RST_N)
            ram_addr <= '0;
        else if (state == S_IDLE && start_sending)
            ram_addr <= ADDR_W'(segment_num) * PL_A;
        else if (state == S_PAYLOAD && cnt >= 16'd3 && cnt < ADDR_STOP)
            ram_addr <= ram_addr + ADDR_ONE;
    end

endmodule

// File: tb/tb_udp_frame_gen.sv
// Bench for udp_frame_gen with a 16-byte payload and a 10-bit RAM address.
module tb_udp_frame_gen;

    localparam int PL = 16;
    localparam int AW = 10;
    localparam logic [47:0] T_DST    = 48'hFFFFFF_FFFFFF;
    localparam logic [47:0] T_SRC    = 48'h000A35_000001;
    localparam logic [31:0] T_SRC_IP = 32'hC0A8_010A;
    localparam logic [31:0] T_DST_IP = 32'hC0A8_0101;
    localparam logic [15:0] T_PORT   = 16'd4660;

    logic          clk125MHz = 1'b0;
    logic          RST_N = 1'b0;
    logic          start_sending = 1'b0;
    logic [15:0]   segment_num = 16'd0;
    logic [7:0]    txid = 8'd0;
    logic [7:0]    aux = 8'd0;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          busy;
    logic [2:0]    dbg_state;

    logic [7:0]    mem [0:1023];

    int n_total = 0;
    int n_bad   = 0;

    // {is_data, expected address of data byte, expected byte}
    logic [AW+8:0] exp_q[$];
    logic [31:0]   m_crc;

    // monitor state
    int            cyc = 0;
    int            en_idx = 0;
    int            busy_run = 0;
    int            last_en_cyc = 0;
    bit            chk_gap = 1'b0;
    logic [31:0]   cap_tag = 32'h0;
    logic [AW-1:0] cap_addr = '0;
    logic [AW-1:0] prev_addr = '0;

    typedef struct {
        logic [15:0]   seg;
        logic [7:0]    tid;
        logic [7:0]    ax;
        logic [31:0]   exp_tag;
        logic [AW-1:0] exp_addr;
    } vec_t;
    vec_t vecs[5];

    udp_frame_gen #(
        .PAYLOAD_LEN(PL),
        .ADDR_W(AW)
    ) dut (
        .clk125MHz(clk125MHz),
        .RST_N(RST_N),
        .start_sending(start_sending),
        .segment_num(segment_num),
        .txid(txid),
        .aux(aux),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .tx_data(tx_data),
        .tx_en(tx_en),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock and RAM model (1-cycle read latency)
    always #4 clk125MHz = ~clk125MHz;

    always @(posedge clk125MHz) ram_data <= mem[ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // bit-serial reference CRC-32 (reflected)
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic logic [15:0] ip_csum();
        logic [15:0] w[9];
        int s;
        w = '{16'h4500, 16'(32 + PL), 16'h0000, 16'h4000, 16'h4011,
              T_SRC_IP[31:16], T_SRC_IP[15:0], T_DST_IP[31:16], T_DST_IP[15:0]};
        s = 0;
        for (int i = 0; i < 9; i++) s = s + int'(w[i]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic put(input logic [7:0] b, input bit crc_on, input bit isd, input logic [AW-1:0] a);
        exp_q.push_back({isd, a, b});
        if (crc_on) m_crc = crc_step(m_crc, b);
    endtask

    task automatic put_field(input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) put(v[8*i +: 8], 1'b1, 1'b0, '0);
    endtask

    // reference frame: pushes every expected tx byte in order
    task automatic push_frame(input logic [15:0] seg, input logic [7:0] tid, input logic [7:0] ax);
        logic [31:0] f;
        int a;
        m_crc = 32'hFFFFFFFF;
        repeat (7) put(8'h55, 1'b0, 1'b0, '0);
        put(8'hD5, 1'b0, 1'b0, '0);
        put_field(T_DST, 6);
        put_field(T_SRC, 6);
        put_field(48'h0800, 2);
        put_field(48'h4500, 2);
        put_field(48'(32 + PL), 2);
        put_field(48'h0000, 2);
        put_field(48'h4000, 2);
        put_field(48'h40, 1);
        put_field(48'h11, 1);
        put_field({32'h0, ip_csum()}, 2);
        put_field({16'h0, T_SRC_IP}, 4);
        put_field({16'h0, T_DST_IP}, 4);
        put_field({32'h0, T_PORT}, 2);
        put_field({32'h0, T_PORT}, 2);
        put_field(48'(12 + PL), 2);
        put_field(48'h0000, 2);
        put(tid, 1'b1, 1'b0, '0);
        put(ax, 1'b1, 1'b0, '0);
        put(seg[15:8], 1'b1, 1'b0, '0);
        put(seg[7:0], 1'b1, 1'b0, '0);
        for (int k = 0; k < PL; k++) begin
            a = (int'(seg) * PL + k) % 1024;
            put(mem[a], 1'b1, 1'b1, AW'(a));
        end
        f = ~m_crc;
        for (int i = 0; i < 4; i++) put(f[8*i +: 8], 1'b0, 1'b0, '0);
    endtask

    // monitor / scoreboard: sampled on the falling edge
    always @(negedge clk125MHz) begin
        logic [AW+8:0] e;
        cyc++;
        if (RST_N !== 1'b1) begin
            busy_run = 0;
            en_idx   = 0;
        end else begin
            if (tx_en === 1'b1) begin
                if (chk_gap && en_idx == 0) begin
                    check("b2b_idle_cycles", cyc - last_en_cyc - 1, 13);
                    chk_gap = 1'b0;
                end
                if (en_idx >= 50 && en_idx <= 53) cap_tag = {cap_tag[23:0], tx_data};
                if (en_idx == 53) cap_addr = ram_addr;
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_tx: got byte %0h, want no transmission (t=%0t)", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e[7:0]);
                    if (e[AW+8]) check("ram_addr", prev_addr, e[AW+7:8]);
                end
                en_idx++;
                last_en_cyc = cyc;
            end else begin
                en_idx = 0;
            end
            if (busy === 1'b1) busy_run++;
            else if (busy_run > 0) begin
                check("busy_len", busy_run, 70 + PL);
                busy_run = 0;
            end
        end
        prev_addr = ram_addr;
    end

    // driver: called on a falling edge while the DUT is idle
    task automatic send(input logic [15:0] s, input logic [7:0] t, input logic [7:0] a);
        segment_num   = s;
        txid          = t;
        aux           = a;
        start_sending = 1'b1;
        push_frame(s, t, a);
        @(negedge clk125MHz);
        start_sending = 1'b0;
        segment_num   = 16'($urandom_range(0, 65535));
        txid          = 8'($urandom_range(0, 255));
        aux           = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk125MHz);
        if (i >= 400) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: busy still high after 400 cycles, want low", name);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        int i;
        for (i = 0; i < 400 && dbg_state !== st; i++) @(negedge clk125MHz);
        if (i >= 400) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: state %0d never reached, stuck at %0d", name, st, dbg_state);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        vecs[0] = '{seg: 16'd2,      tid: 8'd1, ax: 8'd5,   exp_tag: 32'h01050002, exp_addr: 10'd32};
        vecs[1] = '{seg: 16'd64,     tid: 8'd3, ax: 8'd0,   exp_tag: 32'h03000040, exp_addr: 10'd0};
        vecs[2] = '{seg: 16'hABCD,   tid: 8'd2, ax: 8'hFF,  exp_tag: 32'h02FFABCD, exp_addr: 10'd208};
        vecs[3] = '{seg: 16'd63,     tid: 8'd4, ax: 8'd1,   exp_tag: 32'h0401003F, exp_addr: 10'd1008};
        vecs[4] = '{seg: 16'h0041,   tid: 8'd5, ax: 8'h80,  exp_tag: 32'h05800041, exp_addr: 10'd16};

        // T1: reset held with start asserted
        RST_N = 1'b0;
        start_sending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk125MHz);
            check("rst_tx_en", tx_en, 0);
            check("rst_busy", busy, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_tx_data", tx_data, 0);
        end
        RST_N = 1'b1;
        start_sending = 1'b0;
        repeat (20) @(negedge clk125MHz);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_state", dbg_state, 0);

        // T2/T5: table of frames, sent back-to-back
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].seg, vecs[v].tid, vecs[v].ax);
            wait_idle("frame_done");
            check("tag", cap_tag, vecs[v].exp_tag);
            check("first_addr", cap_addr, vecs[v].exp_addr);
            check("queue_drained", exp_q.size(), 0);
        end

        // T3: start pulse during payload must be ignored
        repeat (3) @(negedge clk125MHz);
        send(16'd2, 8'd1, 8'd5);
        wait_state(3'd3, "reach_payload");
        repeat (6) @(negedge clk125MHz);
        segment_num   = 16'd7;
        start_sending = 1'b1;
        @(negedge clk125MHz);
        start_sending = 1'b0;
        wait_idle("ignored_start_frame");
        check("ignored_tag", cap_tag, 32'h01050002);
        repeat (100) @(negedge clk125MHz);
        check("no_second_frame_busy", busy, 0);
        check("no_second_frame_q", exp_q.size(), 0);

        // T4: back-to-back, start in the first idle cycle
        send(16'd5, 8'd2, 8'd9);
        wait_idle("b2b_first");
        chk_gap = 1'b1;
        send(16'd6, 8'd3, 8'd10);
        wait_idle("b2b_second");
        check("b2b_gap_measured", chk_gap, 0);
        check("b2b_tag", cap_tag, 32'h030A0006);

        // T6: one-cycle reset during the header, then a clean frame
        repeat (4) @(negedge clk125MHz);
        send(16'd9, 8'd1, 8'd1);
        wait_state(3'd2, "reach_header");
        repeat (5) @(negedge clk125MHz);
        @(posedge clk125MHz);
        #1 RST_N = 1'b0;
        @(posedge clk125MHz);
        #1;
        exp_q.delete();
        RST_N = 1'b1;
        @(negedge clk125MHz);
        check("abort_tx_en", tx_en, 0);
        check("abort_busy", busy, 0);
        send(16'd9, 8'd1, 8'd1);
        wait_idle("after_abort");
        check("after_abort_tag", cap_tag, 32'h01010009);
        check("after_abort_addr", cap_addr, 10'd144);

        repeat (30) @(negedge clk125MHz);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
